// File: rtl/pwm_rgb_encoder.sv
// rtl/pwm_rgb_encoder.sv - double-buffered 255-step PWM driver for the three RGB LED channels
// Build option PWM_PHASE_STAGGER_EN offsets the green/blue compare phase by 85/170 steps.
module pwm_rgb_encoder #(
    parameter int PRESCALE = 196
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] R_time_in,
    input  logic [7:0] G_time_in,
    input  logic [7:0] B_time_in,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       period_start
);

    localparam int               PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
    localparam logic [7:0]       STEP_LAST = 8'd254;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic [7:0]       shadow_r_q, shadow_r_d;
    logic [7:0]       shadow_g_q, shadow_g_d;
    logic [7:0]       shadow_b_q, shadow_b_d;
    logic             pwm_r_q, pwm_r_d;
    logic             pwm_g_q, pwm_g_d;
    logic             pwm_b_q, pwm_b_d;
    logic             period_start_q, period_start_d;

    logic             tick;
    logic             wrap;
    logic [7:0]       eff_r, eff_g, eff_b;

`ifdef PWM_PHASE_STAGGER_EN
    localparam logic [7:0] OFF_R = 8'd0;
    localparam logic [7:0] OFF_G = 8'd85;
    localparam logic [7:0] OFF_B = 8'd170;

    // Step position shifted by a channel offset, folded back into 0..254.
    function automatic logic [7:0] phase_shift(input logic [7:0] step, input logic [7:0] off);
        logic [8:0] sum;
        sum = {1'b0, step} + {1'b0, off};
        if (sum >= 9'd255) begin
            sum = sum - 9'd255;
        end
        return sum[7:0];
    endfunction

    always_comb begin
        eff_r = phase_shift(step_cnt_q, OFF_R);
        eff_g = phase_shift(step_cnt_q, OFF_G);
        eff_b = phase_shift(step_cnt_q, OFF_B);
    end
`else
    always_comb begin
        eff_r = step_cnt_q;
        eff_g = step_cnt_q;
        eff_b = step_cnt_q;
    end
`endif

    always_comb begin
        tick = enable && (pre_cnt_q == PRE_LAST);
        wrap = tick && (step_cnt_q == STEP_LAST);

        pre_cnt_d  = '0;
        step_cnt_d = 8'd0;
        if (enable) begin
            pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_ONE;
            step_cnt_d = step_cnt_q;
            if (tick) begin
                step_cnt_d = wrap ? 8'd0 : step_cnt_q + 8'd1;
            end
        end

        // Shadows follow the inputs while idle so a restart begins with current duties.
        shadow_r_d = shadow_r_q;
        shadow_g_d = shadow_g_q;
        shadow_b_d = shadow_b_q;
        if (!enable || wrap) begin
            shadow_r_d = R_time_in;
            shadow_g_d = G_time_in;
            shadow_b_d = B_time_in;
        end

        pwm_r_d        = enable && (eff_r < shadow_r_q);
        pwm_g_d        = enable && (eff_g < shadow_g_q);
        pwm_b_d        = enable && (eff_b < shadow_b_q);
        period_start_d = enable && (pre_cnt_q == '0) && (step_cnt_q == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            step_cnt_q     <= 8'd0;
            shadow_r_q     <= 8'd0;
            shadow_g_q     <= 8'd0;
            shadow_b_q     <= 8'd0;
            pwm_r_q        <= 1'b0;
            pwm_g_q        <= 1'b0;
            pwm_b_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            step_cnt_q     <= step_cnt_d;
            shadow_r_q     <= shadow_r_d;
            shadow_g_q     <= shadow_g_d;
            shadow_b_q     <= shadow_b_d;
            pwm_r_q        <= pwm_r_d;
            pwm_g_q        <= pwm_g_d;
            pwm_b_q        <= pwm_b_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_r        = pwm_r_q;
    assign pwm_g        = pwm_g_q;
    assign pwm_b        = pwm_b_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_rgb_encoder.sv
// tb/tb_pwm_rgb_encoder.sv - directed self-checking bench for pwm_rgb_encoder with PRESCALE=2
module tb_pwm_rgb_encoder;

    localparam int PRESCALE = 2;
    localparam int PERIOD   = 255 * PRESCALE;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] r_in, g_in, b_in;
    logic       pwm_r, pwm_g, pwm_b, period_start;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm_rgb_encoder #(.PRESCALE(PRESCALE)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .R_time_in    (r_in),
        .G_time_in    (g_in),
        .B_time_in    (b_in),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b),
        .period_start (period_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Counts high samples over one period starting at the current sample.
    task automatic measure(input int change_at, input logic [7:0] new_r,
                           output int hr, output int hg, output int hb,
                           output int ps_cnt, output bit ps_first);
        hr = 0; hg = 0; hb = 0; ps_cnt = 0;
        ps_first = (period_start === 1'b1);
        for (int i = 0; i < PERIOD; i++) begin
            if (i == change_at) r_in = new_r;
            if (pwm_r === 1'b1) hr++;
            if (pwm_g === 1'b1) hg++;
            if (pwm_b === 1'b1) hb++;
            if (period_start === 1'b1) ps_cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({pwm_r, pwm_g, pwm_b, period_start} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b expected 0000", {pwm_r, pwm_g, pwm_b, period_start});
            end
        end
    endtask

    task automatic test_duty();
        int hr, hg, hb, pc; bit pf, ok;
        r_in = 8'd0; g_in = 8'd255; b_in = 8'd128;
        rst = 1'b0;
        wait_ps(4, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL first_period_start: got 0 expected 1"); end
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        vectors++;
        if (hr + hg + hb !== 0) begin
            miscompares++;
            $display("FAIL pre_wrap_highs: got %0d expected 0", hr + hg + hb);
        end
        for (int p = 0; p < 3; p++) begin
            measure(-1, 8'd0, hr, hg, hb, pc, pf);
            vectors++;
            if (hr !== 0) begin miscompares++; $display("FAIL duty0_r: got %0d expected 0", hr); end
            vectors++;
            if (hg !== 510) begin miscompares++; $display("FAIL duty255_g: got %0d expected 510", hg); end
            vectors++;
            if (hb !== 256) begin miscompares++; $display("FAIL duty128_b: got %0d expected 256", hb); end
            vectors++;
            if (pc !== 1 || pf !== 1'b1) begin
                miscompares++;
                $display("FAIL period_start_spacing: got count %0d first %0d expected 1 1", pc, pf);
            end
        end
    endtask

    task automatic test_midchange();
        int hr, hg, hb, pc; bit pf;
        r_in = 8'd64;
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        vectors++;
        if (hr !== 0) begin miscompares++; $display("FAIL old_shadow_r: got %0d expected 0", hr); end
        measure(200, 8'd200, hr, hg, hb, pc, pf);
        vectors++;
        if (hr !== 128) begin miscompares++; $display("FAIL midchange_r: got %0d expected 128", hr); end
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        vectors++;
        if (hr !== 400) begin miscompares++; $display("FAIL after_change_r: got %0d expected 400", hr); end
    endtask

    task automatic test_enable_toggle();
        int hr, hg, hb, pc, highs; bit pf;
        for (int i = 0; i < 100; i++) step();
        vectors++;
        if (pwm_r !== 1'b1) begin miscompares++; $display("FAIL before_disable_r: got %b expected 1", pwm_r); end
        enable = 1'b0;
        r_in = 8'd10;
        highs = 0;
        for (int i = 0; i < 21; i++) begin
            step();
            highs += (pwm_r === 1'b1) + (pwm_g === 1'b1) + (pwm_b === 1'b1) + (period_start === 1'b1);
        end
        vectors++;
        if (highs !== 0) begin miscompares++; $display("FAIL disabled_outputs: got %0d highs expected 0", highs); end
        enable = 1'b1;
        step();
        vectors++;
        if (period_start !== 1'b1 || pwm_r !== 1'b1) begin
            miscompares++;
            $display("FAIL reenable_first: got ps %b r %b expected 1 1", period_start, pwm_r);
        end
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        vectors++;
        if (hr !== 20) begin miscompares++; $display("FAIL reenable_r: got %0d expected 20", hr); end
        vectors++;
        if (pc !== 1) begin miscompares++; $display("FAIL reenable_ps_count: got %0d expected 1", pc); end
    endtask

    task automatic test_reset_mid();
        int hr, hg, hb, pc; bit pf, ok;
        r_in = 8'd255;
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        for (int i = 0; i < 240; i++) step();
        vectors++;
        if (pwm_r !== 1'b1) begin miscompares++; $display("FAIL before_rst_r: got %b expected 1", pwm_r); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (pwm_r !== 1'b0 || period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL after_rst: got r %b ps %b expected 0 0", pwm_r, period_start);
        end
        wait_ps(4, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rst_period_start: got 0 expected 1"); end
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        vectors++;
        if (hr !== 0) begin miscompares++; $display("FAIL rst_first_period_r: got %0d expected 0", hr); end
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        vectors++;
        if (hr !== 510) begin miscompares++; $display("FAIL rst_resume_r: got %0d expected 510", hr); end
    endtask

    task automatic test_extremes();
        int hr, hg, hb, pc; bit pf;
        r_in = 8'd1; g_in = 8'd254; b_in = 8'd0;
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        vectors++;
        if (hr !== 2) begin miscompares++; $display("FAIL duty1_r: got %0d expected 2", hr); end
        vectors++;
        if (hg !== 508) begin miscompares++; $display("FAIL duty254_g: got %0d expected 508", hg); end
        vectors++;
        if (hb !== 0) begin miscompares++; $display("FAIL duty0_b: got %0d expected 0", hb); end
    endtask

    task automatic test_phase();
        int hr, hg, hb, pc; bit pf;
        int fr, fg, fb, exp_fg, exp_fb;
`ifdef PWM_PHASE_STAGGER_EN
        exp_fg = 340; exp_fb = 170;
`else
        exp_fg = 0;   exp_fb = 0;
`endif
        r_in = 8'd85; g_in = 8'd85; b_in = 8'd85;
        measure(-1, 8'd0, hr, hg, hb, pc, pf);
        fr = -1; fg = -1; fb = -1; hr = 0; hg = 0; hb = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_r === 1'b1) begin hr++; if (fr < 0) fr = i; end
            if (pwm_g === 1'b1) begin hg++; if (fg < 0) fg = i; end
            if (pwm_b === 1'b1) begin hb++; if (fb < 0) fb = i; end
            step();
        end
        vectors++;
        if (fr !== 0 || hr !== 170) begin
            miscompares++;
            $display("FAIL phase_r: got first %0d count %0d expected 0 170", fr, hr);
        end
        vectors++;
        if (fg !== exp_fg || hg !== 170) begin
            miscompares++;
            $display("FAIL phase_g: got first %0d count %0d expected %0d 170", fg, hg, exp_fg);
        end
        vectors++;
        if (fb !== exp_fb || hb !== 170) begin
            miscompares++;
            $display("FAIL phase_b: got first %0d count %0d expected %0d 170", fb, hb, exp_fb);
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_midchange();
        test_enable_toggle();
        test_reset_mid();
        test_extremes();
        test_phase();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
